// File: rtl/bch_dvb_enc_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bch_dvb_enc_sched_pkg
// Description : Shared types and constants for the two-requester BCH encoder
//               input scheduler (FSM state encoding, requester count).
// Revision    : 1.0 - initial release
// ============================================================================
package bch_dvb_enc_sched_pkg;

  // Number of requesters sharing the encoder input port
  localparam int NREQ = 2;

  // Last-served value after reset: requester 1, so requester 0 wins the first tie
  localparam logic LAST_SERVED_RST = 1'b1;

  // Scheduler FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage : bch_dvb_enc_sched_pkg
`default_nettype wire

// File: rtl/bch_dvb_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : bch_dvb_rr_arb2
// Description : Two-way round-robin tie-break. A lone request is granted
//               directly; on a tie the requester not served last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module bch_dvb_rr_arb2
  import bch_dvb_enc_sched_pkg::*;
(
  input  logic [NREQ-1:0] ireq,
  input  logic            ilast,   // id of the requester served last
  output logic [NREQ-1:0] ogrant   // one-hot, zero when nothing requests
);

  // Pure combinational pick: pass single requests through, alternate on ties
  always_comb begin
    ogrant = ireq;
    if (ireq == 2'b11) begin
      ogrant = ilast ? 2'b01 : 2'b10;
    end
  end

endmodule : bch_dvb_rr_arb2
`default_nettype wire

// File: rtl/bch_dvb_enc_sched.sv
`default_nettype none
// ============================================================================
// Module      : bch_dvb_enc_sched
// Description : Schedules bit-serial frames from two requesters into a single
//               BCH encoder input. One requester owns the encoder for pK data
//               bits, then the scheduler waits in FLUSH for the encoder's last
//               parity bit before arbitrating again.
//               Optional flush watchdog: define BCH_DVB_ENC_SCHED_WDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bch_dvb_enc_sched
  import bch_dvb_enc_sched_pkg::*;
#(
  parameter int pK     = 16,
  parameter int pTAG_W = 1,
  parameter int pWDOG  = 1024
) (
  input  logic                   iclk,
  input  logic                   ireset,
  input  logic                   iclkena,
  input  logic [NREQ-1:0]        ireq,
  input  logic [NREQ-1:0]        ival,
  input  logic [NREQ-1:0]        idat,
  input  logic [NREQ*pTAG_W-1:0] itag,
  output logic [NREQ-1:0]        oready,
  output logic                   oenc_sop,
  output logic                   oenc_eop,
  output logic                   oenc_eof,
  output logic                   oenc_val,
  output logic                   oenc_dat,
  output logic [pTAG_W:0]        oenc_tag,
  input  logic                   ienc_val,
  input  logic                   ienc_eop,
  output logic [NREQ-1:0]        ogrant,
  output logic                   obusy,
  output logic                   oerr
);

  localparam int              CNT_W    = (pK > 2) ? $clog2(pK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(pK - 1);

  // Reject nonsensical configurations at elaboration
  if (pK < 2 || pTAG_W < 1 || pWDOG < 1) begin : g_param_check
    $error("bch_dvb_enc_sched: pK must be >= 2, pTAG_W and pWDOG >= 1");
  end

  state_t             state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               enc_val_q, enc_val_d;
  logic               enc_sop_q, enc_sop_d;
  logic               enc_eop_q, enc_eop_d;
  logic               enc_dat_q, enc_dat_d;
  logic [pTAG_W:0]    enc_tag_q, enc_tag_d;

  logic [NREQ-1:0]    arb_grant;
  logic               gid;
  logic               accept;
  logic [pTAG_W-1:0]  tag_sel;

`ifdef BCH_DVB_ENC_SCHED_WDOG_EN
  localparam int               WD_W    = (pWDOG > 2) ? $clog2(pWDOG) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(pWDOG - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            wd_fire;
  // pWDOG-th consecutive FLUSH cycle
  assign wd_fire = (wd_q == WD_LAST);
  assign oerr    = err_q;
`else
  assign oerr    = 1'b0;
`endif

  bch_dvb_rr_arb2 u_arb (
    .ireq   (ireq),
    .ilast  (last_q),
    .ogrant (arb_grant)
  );

  // Owner id and its per-requester fields
  assign gid     = grant_q[1];
  assign tag_sel = itag[(gid ? pTAG_W : 0) +: pTAG_W];

  assign oready  = (iclkena && (state_q == ST_DATA)) ? grant_q : '0;
  assign accept  = |(ival & oready);

  assign ogrant   = grant_q;
  assign obusy    = (state_q != ST_IDLE);
  assign oenc_val = enc_val_q;
  assign oenc_sop = enc_sop_q;
  assign oenc_eop = enc_eop_q;
  assign oenc_eof = enc_eop_q;
  assign oenc_dat = enc_dat_q;
  assign oenc_tag = enc_tag_q;

  // Next-state, counter and output-register logic; everything holds when iclkena=0
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    enc_val_d = enc_val_q;
    enc_sop_d = enc_sop_q;
    enc_eop_d = enc_eop_q;
    enc_dat_d = enc_dat_q;
    enc_tag_d = enc_tag_q;
`ifdef BCH_DVB_ENC_SCHED_WDOG_EN
    wd_d      = wd_q;
    err_d     = err_q;
`endif
    if (iclkena) begin
      // Output strobes are single-cycle; only an accept raises them
      enc_val_d = 1'b0;
      enc_sop_d = 1'b0;
      enc_eop_d = 1'b0;
      enc_dat_d = 1'b0;
`ifdef BCH_DVB_ENC_SCHED_WDOG_EN
      err_d     = 1'b0;
      wd_d      = (state_q == ST_FLUSH) ? wd_q + 1'b1 : '0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (|ireq) begin
            grant_d = arb_grant;
            cnt_d   = '0;
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (accept) begin
            enc_val_d = 1'b1;
            enc_dat_d = idat[gid];
            enc_sop_d = (cnt_q == '0);
            enc_eop_d = (cnt_q == CNT_LAST);
            if (cnt_q == '0) begin
              enc_tag_d = {gid, tag_sel};
            end
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = ST_FLUSH;
            end else begin
              cnt_d   = cnt_q + 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (ienc_val && ienc_eop) begin
            state_d = ST_IDLE;
            grant_d = '0;
            last_d  = gid;
          end
`ifdef BCH_DVB_ENC_SCHED_WDOG_EN
          else if (wd_fire) begin
            state_d = ST_IDLE;
            grant_d = '0;
            last_d  = gid;
            err_d   = 1'b1;
          end
`endif
        end
        default: begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      last_q    <= LAST_SERVED_RST;
      cnt_q     <= '0;
      enc_val_q <= 1'b0;
      enc_sop_q <= 1'b0;
      enc_eop_q <= 1'b0;
      enc_dat_q <= 1'b0;
      enc_tag_q <= '0;
`ifdef BCH_DVB_ENC_SCHED_WDOG_EN
      wd_q      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      enc_val_q <= enc_val_d;
      enc_sop_q <= enc_sop_d;
      enc_eop_q <= enc_eop_d;
      enc_dat_q <= enc_dat_d;
      enc_tag_q <= enc_tag_d;
`ifdef BCH_DVB_ENC_SCHED_WDOG_EN
      wd_q      <= wd_d;
      err_q     <= err_d;
`endif
    end
  end

endmodule : bch_dvb_enc_sched
`default_nettype wire

// File: tb/tb_bch_dvb_enc_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_bch_dvb_enc_sched
// Description : Scoreboard bench for bch_dvb_enc_sched (pK=16, pTAG_W=1,
//               pWDOG=32). Watchdog scenario active with
//               BCH_DVB_ENC_SCHED_WDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bch_dvb_enc_sched;

  localparam int K  = 16;
  localparam int TW = 1;
  localparam int WD = 32;

  logic          iclk = 1'b0;
  logic          ireset, iclkena;
  logic [1:0]    ireq, ival, idat;
  logic [2*TW-1:0] itag;
  logic [1:0]    oready;
  logic          oenc_sop, oenc_eop, oenc_eof, oenc_val, oenc_dat;
  logic [TW:0]   oenc_tag;
  logic          ienc_val, ienc_eop;
  logic [1:0]    ogrant;
  logic          obusy, oerr;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic        dat;
    logic [TW:0] tag;
  } beat_t;

  beat_t exp_q[$];
  beat_t exp_b, act_b;
  int    checks = 0;
  int    errors = 0;
  int    nbeats = 0;
  logic  en_at_edge = 1'b0;

  bch_dvb_enc_sched #(.pK(K), .pTAG_W(TW), .pWDOG(WD)) dut (
    .iclk     (iclk),
    .ireset   (ireset),
    .iclkena  (iclkena),
    .ireq     (ireq),
    .ival     (ival),
    .idat     (idat),
    .itag     (itag),
    .oready   (oready),
    .oenc_sop (oenc_sop),
    .oenc_eop (oenc_eop),
    .oenc_eof (oenc_eof),
    .oenc_val (oenc_val),
    .oenc_dat (oenc_dat),
    .oenc_tag (oenc_tag),
    .ienc_val (ienc_val),
    .ienc_eop (ienc_eop),
    .ogrant   (ogrant),
    .obusy    (obusy),
    .oerr     (oerr)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // A registered beat is new only if the DUT was enabled at the producing edge
  always @(posedge iclk) en_at_edge <= iclkena;

  // Monitor: pop and compare each beat the DUT presents
  always @(negedge iclk) begin
    if (!ireset && en_at_edge && oenc_val) begin
      act_b = '{sop: oenc_sop, eop: oenc_eop, dat: oenc_dat, tag: oenc_tag};
      nbeats++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %0h expected none at %0t", act_b, $time);
      end else begin
        exp_b = exp_q.pop_front();
        chk("beat", 32'(act_b), 32'(exp_b));
        chk("eof", 32'(oenc_eof), 32'(exp_b.eop));
      end
    end
  end

  task automatic all_zero(input string name);
    chk(name, {oenc_sop, oenc_eop, oenc_eof, oenc_val, oenc_dat, oenc_tag,
               ogrant, obusy, oerr, oready}, 32'd0);
  endtask

  task automatic do_reset();
    ireset = 1'b1;
    #1;
    all_zero("reset_outputs");
    exp_q.delete();
    repeat (2) @(posedge iclk);
    #1;
    ireset = 1'b0;
  endtask

  // Drive nbits of a frame for requester id; pattern 1010... starting with 1.
  // gap: idle cycle before each bit after the first. stall_at: bit index before
  // which iclkena is dropped for 5 cycles. drop_at: bit index at which ireq[id] drops.
  task automatic send_frame(input int id, input logic [TW-1:0] tag, input int nbits,
                            input bit gap, input int stall_at, input int drop_at);
    logic [1:0]  oh;
    logic        b;
    int          w;
    logic [15:0] snap;
    oh = 2'b01 << id;
    itag[id*TW +: TW] = tag;
    w = 0;
    @(negedge iclk);
    while (ogrant !== oh && w < 20) begin
      @(negedge iclk);
      w++;
    end
    chk("grant", 32'(ogrant), 32'(oh));
    if (ogrant !== oh) return;
    for (int i = 0; i < nbits; i++) begin
      b = ~i[0];
      if (gap && i > 0) begin
        ival[id] = 1'b0;
        @(posedge iclk);
        #1;
      end
      if (i == drop_at) ireq[id] = 1'b0;
      ival[id] = 1'b1;
      idat[id] = b;
      ienc_val = (i == 3);
      ienc_eop = (i == 3);
      if (i == stall_at) begin
        snap = {oenc_val, oenc_sop, oenc_eop, oenc_eof, oenc_dat, oenc_tag, ogrant, obusy, 5'd0};
        iclkena = 1'b0;
        repeat (5) begin
          #1;
          chk("stall_ready", 32'(oready), 32'd0);
          @(posedge iclk);
          #1;
          chk("stall_frozen",
              32'({oenc_val, oenc_sop, oenc_eop, oenc_eof, oenc_dat, oenc_tag, ogrant, obusy, 5'd0}),
              32'(snap));
        end
        iclkena = 1'b1;
      end
      #0;
      chk("ready", 32'(oready), 32'(oh));
      exp_q.push_back('{sop: (i == 0), eop: (i == K-1), dat: b, tag: {id[0], tag}});
      @(posedge iclk);
      #1;
      if (i == 0) itag[id*TW +: TW] = ~tag;  // later tag changes must not leak
    end
    ival[id] = 1'b0;
    ienc_val = 1'b0;
    ienc_eop = 1'b0;
  endtask

  // Hold FLUSH, check ienc_eop needs ienc_val, then release with val&eop
  task automatic finish_flush(input int id);
    logic [1:0] oh;
    oh = 2'b01 << id;
    ienc_eop = 1'b1;
    repeat (4) @(posedge iclk);
    #1;
    ienc_eop = 1'b0;
    chk("flush_busy", 32'({obusy, ogrant, oready, oerr}), 32'({1'b1, oh, 2'b00, 1'b0}));
    ienc_val = 1'b1;
    ienc_eop = 1'b1;
    @(posedge iclk);
    #1;
    ienc_val = 1'b0;
    ienc_eop = 1'b0;
    chk("flush_done", 32'({obusy, ogrant}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    ireset = 1'b1; iclkena = 1'b1; ireq = 2'b00; ival = 2'b00; idat = 2'b00;
    itag = '0; ienc_val = 1'b0; ienc_eop = 1'b0;
    #1;
    all_zero("reset_initial");
    repeat (3) @(posedge iclk);
    #1;
    ireset = 1'b0;

    // Single requester 0, 1010... pattern, ireq dropped mid-frame
    ireq = 2'b01;
    send_frame(0, 1'b1, K, 1'b0, -1, 2);
    finish_flush(0);
    @(posedge iclk); #1;
    chk("idle_after_drop", 32'({obusy, ogrant}), 32'd0);

    // Tie held across 3 frames after reset: 0,1,0
    do_reset();
    itag = 2'b01;
    ireq = 2'b11;
    send_frame(0, 1'b1, K, 1'b0, -1, -1);
    finish_flush(0);
    send_frame(1, 1'b0, K, 1'b0, -1, -1);
    finish_flush(1);
    send_frame(0, 1'b1, K, 1'b0, -1, -1);
    ireq = 2'b00;
    finish_flush(0);

    // ival toggling on requester 1
    nbeats = 0;
    ireq = 2'b10;
    send_frame(1, 1'b1, K, 1'b1, -1, -1);
    ireq = 2'b00;
    finish_flush(1);
    chk("toggle_beats", 32'(nbeats), 32'(K));

    // Reset after 7 bits; partial frame discarded, next frame restarts
    ireq = 2'b01;
    send_frame(0, 1'b0, 7, 1'b0, -1, -1);
    @(negedge iclk);
    #2;
    chk("partial_drained", 32'(exp_q.size()), 32'd0);
    do_reset();
    send_frame(0, 1'b1, K, 1'b0, -1, -1);
    finish_flush(0);

    // Clock enable low for 5 cycles mid-frame
    send_frame(0, 1'b0, K, 1'b0, 8, -1);
    ireq = 2'b00;
    finish_flush(0);

`ifdef BCH_DVB_ENC_SCHED_WDOG_EN
    // No ienc_eop: watchdog fires 32 cycles into FLUSH, then regrant
    ireq = 2'b11;
    send_frame(1, 1'b1, K, 1'b0, -1, -1);
    n = 0;
    do begin
      @(negedge iclk);
      n++;
    end while (!oerr && n < 100);
    chk("wdog_cycles", 32'(n), 32'(WD));
    chk("wdog_idle", 32'({oerr, obusy, ogrant}), 32'({1'b1, 1'b0, 2'b00}));
    @(negedge iclk);
    chk("wdog_regrant", 32'({oerr, obusy, ogrant}), 32'({1'b0, 1'b1, 2'b01}));
    send_frame(0, 1'b1, K, 1'b0, -1, -1);
    ireq = 2'b00;
    finish_flush(0);
`else
    n = 0;
    chk("no_wdog_err", 32'(oerr), 32'(n));
`endif

    repeat (3) @(posedge iclk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_bch_dvb_enc_sched
`default_nettype wire
